fetch_unit: RTL and testbench

Instruction-fetch stage for the RV32I core: owns the program counter, issues word requests to instruction memory over a req/gnt/rvalid handshake, and presents one fetched instruction with its PC to the decode stage (`if_id_buffer` input side). Decode can stall the stage, and execute can redirect it on a taken branch. It replaces the free-running `PC`/`add4`/`Mux_A` fetch path with a sequential unit that tolerates wait-stated memory and back-pressure.

---
 rtl/fetch_unit.sv | 185 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : RV32I instruction-fetch stage. Owns the program counter,
//               issues one word request at a time over a req/gnt/rvalid
//               handshake and presents {instr, pc} to decode, with stall
//               back-pressure and single-cycle branch redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [31:0] C_ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_discard;
  logic        w_discard_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_req_pc;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;

  logic        w_consume;
  logic        w_slot_free;
  logic        w_fire;
  logic        w_load_slot;
  logic        w_load_skid;
  logic        w_skid_to_slot;
  logic [31:0] w_target;

  // Decode takes the output slot at this edge when it is valid and not stalled.
  assign w_consume   = if_valid && !stall;
  assign w_slot_free = !if_valid || w_consume;
  assign imem_req    = (r_state == ST_ISSUE) && w_slot_free;
  assign imem_addr   = r_pc;
  assign w_fire      = imem_req && imem_gnt;
  // Masking (rather than slicing) keeps every target bit in use.
  assign w_target    = branch_target & C_ALIGN_MASK;

  // Next-state and datapath-control decode; a redirect overrides all else.
  always_comb begin
    w_state_nxt    = r_state;
    w_discard_nxt  = r_discard;
    w_load_slot    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_slot = 1'b0;
    if (branch_taken) begin
      case (r_state)
        ST_ISSUE: begin
          // A request granted alongside the redirect fetches a stale address.
          if (w_fire) begin
            w_state_nxt   = ST_WAIT;
            w_discard_nxt = 1'b1;
          end
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            w_state_nxt   = ST_ISSUE;
            w_discard_nxt = 1'b0;
          end else begin
            w_discard_nxt = 1'b1;
          end
        end
        default: begin
          w_state_nxt   = ST_ISSUE;
          w_discard_nxt = 1'b0;
        end
      endcase
    end else begin
      case (r_state)
        ST_ISSUE: begin
          if (w_fire) w_state_nxt = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            if (r_discard) begin
              w_discard_nxt = 1'b0;
              w_state_nxt   = ST_ISSUE;
            end else if (w_slot_free) begin
              w_load_slot = 1'b1;
              w_state_nxt = ST_ISSUE;
            end else begin
              w_load_skid = 1'b1;
              w_state_nxt = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (w_consume) begin
            w_skid_to_slot = 1'b1;
            w_state_nxt    = ST_ISSUE;
          end
        end
        default: begin
          w_state_nxt = ST_ISSUE;
        end
      endcase
    end
  end

  // State and discard flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_ISSUE;
      r_discard <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_discard <= w_discard_nxt;
    end
  end

  // Program counter and in-flight address; redirect wins over the +4 advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
    end else begin
      if (branch_taken) begin
        r_pc <= w_target;
      end else if (w_fire) begin
        r_pc <= r_pc + 32'd4;
      end
      if (w_fire) r_req_pc <= r_pc;
    end
  end

  // Output slot toward decode; an empty slot always shows the NOP encoding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
      if_pc    <= RESET_PC;
    end else if (branch_taken) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end else if (w_load_slot) begin
      if_valid <= 1'b1;
      if_instr <= imem_rdata;
      if_pc    <= r_req_pc;
    end else if (w_skid_to_slot) begin
      if_valid <= 1'b1;
      if_instr <= r_skid_instr;
      if_pc    <= r_skid_pc;
    end else if (w_consume) begin
      if_valid <= 1'b0;
      if_instr <= NOP_INSTR;
    end
  end

  // Skid buffer; its contents are meaningful only while in HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_skid_instr <= NOP_INSTR;
      r_skid_pc    <= RESET_PC;
    end else if (w_load_skid) begin
      r_skid_instr <= imem_rdata;
      r_skid_pc    <= r_req_pc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. A memory model answers
//               requests with rdata = address; granted addresses are queued
//               as expected decode outputs and popped on every consume.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] C_NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  fetch_unit #(
    .RESET_PC (C_RESET_PC),
    .NOP_INSTR(C_NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  // Memory model state
  logic        rv_pending = 1'b0;
  logic [31:0] rv_addr = 32'h0;
  int          rv_cnt = 0;
  int          rv_lat = 0;
  logic [31:0] hold_addr = 32'h1;
  int          hold_left = 0;

  // Values sampled just before the last active edge
  logic        s_req = 1'b0;
  logic        s_fire = 1'b0;
  logic        s_rvalid = 1'b0;
  logic        s_branch = 1'b0;
  logic        s_consume = 1'b0;
  logic [31:0] s_addr = 32'h0;
  int          n_cons = 0;

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_pc;
    int          exp_edges;
  } br_vec_t;

  br_vec_t vec[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle();
    logic [31:0] e;
    #1;
    imem_gnt    = imem_req && !(imem_addr == hold_addr && hold_left > 0);
    imem_rvalid = rv_pending && (rv_cnt == 0);
    imem_rdata  = imem_rvalid ? rv_addr : 32'hDEAD_BEEF;
    #1;
    s_req     = imem_req;
    s_addr    = imem_addr;
    s_fire    = imem_req && imem_gnt;
    s_rvalid  = imem_rvalid;
    s_branch  = branch_taken;
    s_consume = if_valid && !stall;
    if (!if_valid) chk("nop_when_invalid", if_instr, C_NOP);
    if (s_consume && !s_branch) begin
      n_cons++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual_pc=%h required=none", if_pc);
      end else begin
        e = exp_q.pop_front();
        chk("if_pc", if_pc, e);
        chk("if_instr", if_instr, e);
      end
    end
    @(posedge clk);
    if (s_req && s_addr == hold_addr && hold_left > 0) hold_left--;
    if (s_rvalid) rv_pending = 1'b0;
    else if (rv_pending && rv_cnt > 0) rv_cnt--;
    if (s_fire) begin
      if (rv_pending) begin
        checks++;
        errors++;
        $display("FAIL two_outstanding actual=2 required=1");
      end
      rv_pending = 1'b1;
      rv_addr    = s_addr;
      rv_cnt     = rv_lat;
    end
    if (s_branch) exp_q.delete();
    else if (s_fire) exp_q.push_back(s_addr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    imem_gnt      = 1'b0;
    imem_rvalid   = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_if_instr", if_instr, C_NOP);
    chk("rst_if_pc", if_pc, C_RESET_PC);
    exp_q.delete();
    rv_pending = 1'b0;
    rv_cnt     = 0;
    hold_left  = 0;
    hold_addr  = 32'h1;
    s_fire     = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int  nreq;
    int  edges;
    logic found;

    vec[0] = '{32'h0000_0102, 32'h0000_0100, 2};
    vec[1] = '{32'h0000_0203, 32'h0000_0200, 2};
    vec[2] = '{32'h0000_0040, 32'h0000_0040, 2};
    vec[3] = '{32'h0000_1001, 32'h0000_1000, 2};
    vec[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFC, 2};

    @(negedge clk);

    // Reset and zero-wait streaming: 0,4,8,12 every two cycles.
    do_reset();
    cycle();
    chk("first_req", {31'b0, s_req}, 32'd1);
    chk("first_addr", s_addr, C_RESET_PC);
    cycle();
    chk("first_valid_2edges", {31'b0, if_valid}, 32'd1);
    chk("first_pc", if_pc, C_RESET_PC);
    n_cons = 0;
    repeat (8) cycle();
    chk("throughput", n_cons, 32'd4);

    // Grant withheld for three cycles on the fetch at 0x8.
    do_reset();
    hold_addr = 32'h8;
    hold_left = 3;
    nreq = 0;
    repeat (14) begin
      cycle();
      if (s_req && s_addr == 32'h8) nreq++;
    end
    chk("gnt_hold_req_cycles", nreq, 32'd4);

    // Stall with 0x4 in the output slot.
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (if_valid && if_pc == 32'h4) found = 1'b1;
    end
    chk("reach_pc4", {31'b0, found}, 32'd1);
    stall = 1'b1;
    nreq = 0;
    repeat (5) begin
      cycle();
      if (s_req) nreq++;
    end
    chk("stall_no_req", nreq, 32'd0);
    chk("stall_hold_pc", if_pc, 32'h4);
    chk("stall_hold_valid", {31'b0, if_valid}, 32'd1);
    stall = 1'b0;
    n_cons = 0;
    found = 1'b0;
    repeat (8) begin
      cycle();
      if (s_fire && s_addr == 32'hC) found = 1'b1;
    end
    chk("stall_release_consumed", n_cons, 32'd4);
    chk("stall_release_fetch_c", {31'b0, found}, 32'd1);

    // Redirect while waiting on the response for 0xC.
    do_reset();
    rv_lat = 1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      cycle();
      if (s_fire && s_addr == 32'hC) found = 1'b1;
    end
    chk("reach_wait_c", {31'b0, found}, 32'd1);
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    cycle();
    branch_taken = 1'b0;
    chk("br_wait_flush", {31'b0, if_valid}, 32'd0);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      if (s_fire) found = 1'b1;
    end
    chk("br_wait_req_seen", {31'b0, found}, 32'd1);
    chk("br_wait_req_addr", s_addr, 32'h100);
    for (int k = 0; k < 10 && !if_valid; k++) cycle();
    chk("br_wait_pc", if_pc, 32'h100);
    rv_lat = 0;

    // Redirect vectors applied with a full slot and stall held high.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      stall = 1'b1;
      for (int k = 0; k < 20 && !if_valid; k++) cycle();
      chk("br_pre_valid", {31'b0, if_valid}, 32'd1);
      branch_taken  = 1'b1;
      branch_target = vec[i].target;
      cycle();
      branch_taken = 1'b0;
      stall = 1'b0;
      chk("br_flush", {31'b0, if_valid}, 32'd0);
      edges = 0;
      cycle();
      edges++;
      chk("br_req", {31'b0, s_req}, 32'd1);
      chk("br_addr", s_addr, vec[i].exp_pc);
      while (!if_valid && edges < 10) begin
        cycle();
        edges++;
      end
      chk("br_edges", edges, vec[i].exp_edges);
      chk("br_pc", if_pc, vec[i].exp_pc);
    end

    // Slot holds 0xFFFF_FFFC: the following fetch wraps to 0.
    stall = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      if (s_fire) found = 1'b1;
    end
    chk("wrap_req_seen", {31'b0, found}, 32'd1);
    chk("wrap_addr", s_addr, 32'h0);

    // Asynchronous reset while a request is in flight.
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, if_valid}, 32'd0);
    chk("async_rst_pc", if_pc, C_RESET_PC);
    chk("async_rst_addr", imem_addr, C_RESET_PC);
    @(negedge clk);
    do_reset();
    n_cons = 0;
    repeat (6) cycle();
    chk("post_reset_run", n_cons, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
